// File: rtl/sar_comparador.sv
// sar_comparador
//   Successive-approximation search controller. Presents a trial value to an
//   external combinational magnitude comparator (X on its "a" side, tentativa
//   on its "b" side), reads back maior/menor/igual and binary-searches
//   MSB-first until X is found.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      begin a search; only looked at in OCIOSO and FIM
//   maior      comparator flag: X >  tentativa
//   menor      comparator flag: X <  tentativa
//   igual      comparator flag: X == tentativa
//   tentativa  registered trial value driven to the comparator
//   resultado  found value, valid with pronto, held until the next start
//   ocupado    high while searching (BUSCA / VERIFICA)
//   pronto     one-cycle pulse when a search ends (success or error)
//   erro       inconsistent comparator response; sticky until next start
//
// Handshake: start is a request level, accepted on any edge where the
// controller is in OCIOSO or FIM (ignored while ocupado=1). Completion is
// signalled by the single-cycle pronto pulse; resultado/erro are valid from
// that cycle until the next accepted start. There is no back-pressure.
//
// Debug: the FSM state is held in state_q (type state_t) for checkers.

module sar_comparador #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             maior,
  input  logic             menor,
  input  logic             igual,
  output logic [WIDTH-1:0] tentativa,
  output logic [WIDTH-1:0] resultado,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  localparam logic [KW-1:0]    K_TOP = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    BUSCA    = 2'd1,
    VERIFICA = 2'd2,
    FIM      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tent_q, tent_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acum_q, acum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             erro_q, erro_d;

  logic [1:0]       n_high;
  logic             flags_ok;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] bit_km1;
  logic [WIDTH-1:0] acum_upd;

  // Exactly one flag must be high; anything else is a broken comparator.
  assign n_high   = 2'(maior) + 2'(menor) + 2'(igual);
  assign flags_ok = (n_high == 2'd1);

  assign bit_k    = ONE << k_q;
  assign bit_km1  = ONE << (k_q - KW'(1));
  // X above the trial keeps the bit, X below clears it.
  assign acum_upd = maior ? (acum_q | bit_k) : (acum_q & ~bit_k);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCIOSO;
      tent_q  <= '0;
      res_q   <= '0;
      acum_q  <= '0;
      k_q     <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tent_q  <= tent_d;
      res_q   <= res_d;
      acum_q  <= acum_d;
      k_q     <= k_d;
      erro_q  <= erro_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    tent_d  = tent_q;
    res_d   = res_q;
    acum_d  = acum_q;
    k_d     = k_q;
    erro_d  = erro_q;

    case (state_q)
      OCIOSO: begin
        tent_d = '0;
      end

      BUSCA: begin
        if (!flags_ok) begin
          erro_d  = 1'b1;
          res_d   = '0;
          state_d = FIM;
        end else if (igual) begin
          res_d   = tent_q;
          state_d = FIM;
        end else if (k_q != '0) begin
          acum_d = acum_upd;
          k_d    = k_q - KW'(1);
          tent_d = acum_upd | bit_km1;
        end else if (maior) begin
          // X above a trial whose LSB is already set cannot happen.
          erro_d  = 1'b1;
          res_d   = '0;
          state_d = FIM;
        end else begin
          // Every bit resolved with bit 0 clear: confirm acumulado itself.
          tent_d  = acum_q;
          state_d = VERIFICA;
        end
      end

      VERIFICA: begin
        if (flags_ok && igual) begin
          res_d = acum_q;
        end else begin
          erro_d = 1'b1;
          res_d  = '0;
        end
        state_d = FIM;
      end

      FIM: begin
        // tentativa holds through FIM and drops to 0 on the way to OCIOSO.
        tent_d  = '0;
        state_d = OCIOSO;
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase

    // A start seen in FIM launches the next search with no idle cycle.
    if ((state_q == OCIOSO || state_q == FIM) && start) begin
      acum_d  = '0;
      k_d     = K_TOP;
      tent_d  = MSB;
      erro_d  = 1'b0;
      state_d = BUSCA;
    end
  end

  // Outputs.
  always_comb begin
    ocupado   = (state_q == BUSCA) || (state_q == VERIFICA);
    pronto    = (state_q == FIM);
    tentativa = tent_q;
    resultado = res_q;
    erro      = erro_q;
  end

endmodule

// File: doc/sar_comparador.md
Name: sar_comparador

Overview:
- Successive-approximation search controller, the consumer side of the magnitude-comparator interface.
- Drives a trial value into an external combinational comparator that compares an unknown operand X (a) against the trial (b).
- Reads back the maior/menor/igual flags and binary-searches MSB-first until X is found.
- Used wherever a value is observable only through a comparator, such as threshold search or SAR conversion.

Parameters:
WIDTH, 8, bit width of the trial value and of the result

Ports:
clk  input  1  system clock, all state changes on the rising edge
rst_n  input  1  reset, synchronous and active-low
start  input  1  begin a new search; sampled only in the OCIOSO and FIM states
maior  input  1  comparator flag: X > tentativa
menor  input  1  comparator flag: X < tentativa
igual  input  1  comparator flag: X == tentativa
tentativa  output  WIDTH  registered trial value presented to the comparator
resultado  output  WIDTH  found value; valid while pronto=1 and held until the next start
ocupado  output  1  high in the BUSCA and VERIFICA states
pronto  output  1  one-cycle pulse when a search ends, successfully or with an error
erro  output  1  comparator response was inconsistent; sticky until the next accepted start

Behaviour:
- Reset, with rst_n=0 sampled at an edge:
  - state returns to OCIOSO
  - tentativa, resultado, acumulado and the bit index k are cleared to 0
  - ocupado, pronto and erro are 0
  - reset mid-search aborts with no pronto pulse.
- Comparator model: flags are combinational from tentativa and are sampled at the edge ending each BUSCA or VERIFICA cycle. There is one trial per cycle.
- Flag check: exactly one of maior, menor or igual must be high. Zero or two or more high means invalid.
- OCIOSO: tentativa=0, ocupado=0. On start=1:
  - acumulado=0, k=WIDTH-1
  - tentativa is set to 1<<(WIDTH-1), so the first trial is visible the cycle after start
  - erro is cleared; go to BUSCA.
- BUSCA, with tentativa = acumulado | (1<<k). At the edge:
  - invalid flags: erro=1, resultado=0, go to FIM
  - igual: resultado=tentativa, go to FIM (early exit)
  - maior with k>0: acumulado keeps bit k
  - menor with k>0: acumulado clears bit k
  - after maior or menor with k>0: k=k-1 and tentativa = new acumulado | (1<<(k-1))
  - maior with k=0: impossible for a consistent comparator, so erro=1, resultado=0, go to FIM
  - menor with k=0: tentativa=acumulado (bit 0 clear), go to VERIFICA.
- VERIFICA, which drives tentativa=acumulado. At the edge:
  - igual: resultado=acumulado, go to FIM
  - any other flag combination: erro=1, resultado=0, go to FIM.
- FIM: pronto=1 for exactly one cycle, ocupado=0, tentativa holds its last value.
  - Next state is OCIOSO.
  - If start=1 in FIM, a new search begins exactly as from OCIOSO, giving back-to-back searches with no idle cycle.
- start while ocupado=1 is ignored, and the search continues unchanged.
- Latency from the start edge to pronto:
  - igual at bit i (i = WIDTH-1 down to 0): WIDTH-i BUSCA cycles, then pronto in the following cycle
  - worst case: WIDTH BUSCA cycles + 1 VERIFICA cycle, then pronto.
- Arithmetic: pure bit set/clear on acumulado. There is no adder and no wrap-around; all values stay within WIDTH bits.
- resultado and erro are stable from the pronto cycle until the next accepted start.

Test Plan:
- Behavioural comparator with X=0xA5, start pulse -> tentativa sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; igual at 0xA5; pronto pulse with resultado=0xA5, erro=0, 8 BUSCA cycles.
- X=0x80 -> first trial 0x80 gives igual; pronto in the cycle after the single BUSCA cycle; resultado=0x80; 1 BUSCA cycle.
- X=0x00 -> trials 0x80, 0x40, ..., 0x01 all answer menor; VERIFICA drives 0x00 and gets igual; resultado=0x00, erro=0; 9 busy cycles. X=0xFF -> trials 0x80, 0xC0, ..., 0xFF with igual at bit 0; resultado=0xFF.
- Faults:
  - maior=menor=1 forced on the 3rd BUSCA cycle -> erro=1, resultado=0, pronto pulse, and erro held until the next start
  - comparator stuck at maior -> erro at k=0.
- start held high through a whole search -> the extra starts are ignored while ocupado=1; a new search begins from FIM with no OCIOSO cycle.
- rst_n=0 during the 4th BUSCA cycle -> next cycle all outputs are 0 and the state is OCIOSO; no pronto pulse; a later start searches correctly.
